// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the 8N1 UART core and its bit timer.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } txState_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rxState_e;

    // Number of system clock cycles spent on one serial bit.
    function automatic int bitCycles(input int clockFrequency, input int baudRate);
        return clockFrequency / baudRate;
    endfunction

    // Offset from a start edge to the middle of the start bit.
    function automatic int halfBit(input int cycles);
        return cycles / 2;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counter that ticks once per bit period; a half load lets the receiver
// align its sampling point with the middle of each bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CYCLES = 1250
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic halfLoad_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int WIDTH = $clog2(CYCLES);
    localparam logic [WIDTH-1:0] FULL_RELOAD = WIDTH'(CYCLES - 1);
    localparam logic [WIDTH-1:0] HALF_RELOAD = WIDTH'(halfBit(CYCLES) - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Loads take priority; while enabled the counter wraps to a full period on each tick.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = FULL_RELOAD;
        end else if (halfLoad_i) begin
            count_d = HALF_RELOAD;
        end else if (enable_i) begin
            if (count_q == '0) begin
                count_d = FULL_RELOAD;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = enable_i && (count_q == '0);

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: one transmitter and one receiver on a shared clock,
// with sticky new-value and error flags for the received byte.
module uart_core
    import uart_pkg::*;
#(
    parameter int clock_frequency = 12000000,
    parameter int baud_rate       = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       clear,
    input  logic       start_transmit,
    input  logic [7:0] data_to_send,
    output logic       busy,
    output logic       error,
    output logic       new_value,
    output logic [7:0] recvd_data
);

    localparam int BIT_CYCLES = bitCycles(clock_frequency, baud_rate);

    txState_e   txState_q, txState_d;
    logic [7:0] txShift_q, txShift_d;
    logic [2:0] txBitCount_q, txBitCount_d;
    logic       txLine_q, txLine_d;
    logic       txLoad, txEnable, txTick;

    rxState_e   rxState_q, rxState_d;
    logic [7:0] rxShift_q, rxShift_d;
    logic [2:0] rxBitCount_q, rxBitCount_d;
    logic [7:0] recvd_q, recvd_d;
    logic       newValue_q, newValue_d;
    logic       error_q, error_d;
    logic       rxMeta_q, rxSync_q, rxPrev_q;
    logic       rxHalfLoad, rxEnable, rxTick;

    uart_bit_timer #(.CYCLES(BIT_CYCLES)) txTimer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (txLoad),
        .halfLoad_i (1'b0),
        .enable_i   (txEnable),
        .tick_o     (txTick)
    );

    uart_bit_timer #(.CYCLES(BIT_CYCLES)) rxTimer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (1'b0),
        .halfLoad_i (rxHalfLoad),
        .enable_i   (rxEnable),
        .tick_o     (rxTick)
    );

    // Transmit sequencing; the next line level is computed alongside the state so tx is a clean flop output.
    always_comb begin
        txState_d    = txState_q;
        txShift_d    = txShift_q;
        txBitCount_d = txBitCount_q;
        txLine_d     = txLine_q;
        txLoad       = 1'b0;
        txEnable     = (txState_q != TX_IDLE);
        case (txState_q)
            TX_IDLE: begin
                txLine_d = 1'b1;
                if (start_transmit) begin
                    txState_d = TX_START;
                    txShift_d = data_to_send;
                    txLoad    = 1'b1;
                    txLine_d  = 1'b0;
                end
            end
            TX_START: begin
                if (txTick) begin
                    txState_d    = TX_DATA;
                    txBitCount_d = 3'd0;
                    txLine_d     = txShift_q[0];
                end
            end
            TX_DATA: begin
                if (txTick) begin
                    if (txBitCount_q == 3'd7) begin
                        txState_d = TX_STOP;
                        txLine_d  = 1'b1;
                    end else begin
                        txBitCount_d = txBitCount_q + 3'd1;
                        txShift_d    = {1'b0, txShift_q[7:1]};
                        txLine_d     = txShift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (txTick) begin
                    txState_d = TX_IDLE;
                end
            end
            default: txState_d = TX_IDLE;
        endcase
    end

    // Transmit state registers; reset forces the line idle on the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            txState_q    <= TX_IDLE;
            txShift_q    <= '0;
            txBitCount_q <= '0;
            txLine_q     <= 1'b1;
        end else begin
            txState_q    <= txState_d;
            txShift_q    <= txShift_d;
            txBitCount_q <= txBitCount_d;
            txLine_q     <= txLine_d;
        end
    end

    // Two-flop synchronizer on the asynchronous serial input, plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    // Receive sequencing and flag handling; a completing byte overrides a simultaneous clear.
    always_comb begin
        rxState_d    = rxState_q;
        rxShift_d    = rxShift_q;
        rxBitCount_d = rxBitCount_q;
        recvd_d      = recvd_q;
        newValue_d   = newValue_q;
        error_d      = error_q;
        rxHalfLoad   = 1'b0;
        rxEnable     = (rxState_q != RX_IDLE);
        if (clear) begin
            newValue_d = 1'b0;
            error_d    = 1'b0;
        end
        case (rxState_q)
            RX_IDLE: begin
                if (rxPrev_q && !rxSync_q) begin
                    rxState_d  = RX_START;
                    rxHalfLoad = 1'b1;
                end
            end
            RX_START: begin
                if (rxTick) begin
                    if (rxSync_q) begin
                        rxState_d = RX_IDLE;
                    end else begin
                        rxState_d    = RX_DATA;
                        rxBitCount_d = 3'd0;
                    end
                end
            end
            RX_DATA: begin
                if (rxTick) begin
                    rxShift_d = {rxSync_q, rxShift_q[7:1]};
                    if (rxBitCount_q == 3'd7) begin
                        rxState_d = RX_STOP;
                    end else begin
                        rxBitCount_d = rxBitCount_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rxTick) begin
                    rxState_d = RX_IDLE;
                    if (rxSync_q) begin
                        recvd_d    = rxShift_q;
                        newValue_d = 1'b1;
                        if (newValue_q && !clear) begin
                            error_d = 1'b1;
                        end
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    // Receive state and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxState_q    <= RX_IDLE;
            rxShift_q    <= '0;
            rxBitCount_q <= '0;
            recvd_q      <= '0;
            newValue_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            rxState_q    <= rxState_d;
            rxShift_q    <= rxShift_d;
            rxBitCount_q <= rxBitCount_d;
            recvd_q      <= recvd_d;
            newValue_q   <= newValue_d;
            error_q      <= error_d;
        end
    end

    assign tx         = txLine_q;
    assign busy       = (txState_q != TX_IDLE) || (rxState_q != RX_IDLE);
    assign error      = error_q;
    assign new_value  = newValue_q;
    assign recvd_data = recvd_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: instance A transmits into instance B, or the
// bench drives B's serial input directly; received bytes go through a scoreboard.
module tb_uart_core;

    localparam int CLK_HZ = 960000;
    localparam int BAUD   = 9600;
    localparam int BIT    = CLK_HZ / BAUD;
    localparam int HALF   = BIT / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       aStart, bStart, aClear, bClear;
    logic [7:0] aData, bData;
    logic       aTx, bTx, aBusy, bBusy, aError, bError, aNewValue, bNewValue;
    logic [7:0] aRecvd, bRecvd;
    logic       driveRx, useLoop;
    logic       bRx;

    int total = 0;
    int bad   = 0;
    logic [7:0] expQ[$];

    int   aFrames = 0;
    logic aBusyPrev = 1'b0;

    assign bRx = useLoop ? aTx : driveRx;

    uart_core #(.clock_frequency(CLK_HZ), .baud_rate(BAUD)) uartA (
        .clk(clk), .rst(rst), .rx(bTx), .tx(aTx), .clear(aClear),
        .start_transmit(aStart), .data_to_send(aData), .busy(aBusy),
        .error(aError), .new_value(aNewValue), .recvd_data(aRecvd)
    );

    uart_core #(.clock_frequency(CLK_HZ), .baud_rate(BAUD)) uartB (
        .clk(clk), .rst(rst), .rx(bRx), .tx(bTx), .clear(bClear),
        .start_transmit(bStart), .data_to_send(bData), .busy(bBusy),
        .error(bError), .new_value(bNewValue), .recvd_data(bRecvd)
    );

    always #5 clk = ~clk;

    // Counts transmitter frames on A by rising edges of its busy output.
    always @(posedge clk) begin
        aBusyPrev <= aBusy;
        if (aBusy === 1'b1 && aBusyPrev === 1'b0) aFrames <= aFrames + 1;
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one serial frame onto B's input at the nominal bit period.
    task automatic applyStimulus(input logic [7:0] value, input logic stopBit);
        driveRx = 1'b0;
        stepCycles(BIT);
        for (int i = 0; i < 8; i++) begin
            driveRx = value[i];
            stepCycles(BIT);
        end
        driveRx = stopBit;
        stepCycles(BIT);
        driveRx = 1'b1;
    endtask

    task automatic waitNewValue(input string tag, input int budget);
        int n = 0;
        while (bNewValue !== 1'b1 && n < budget) begin
            stepCycles(1);
            n++;
        end
        checkOutput(tag, 8'(bNewValue), 8'd1);
    endtask

    task automatic popCompare(input string tag);
        logic [7:0] exp;
        checkOutput({tag, "_queued"}, 8'(expQ.size() > 0), 8'd1);
        if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            checkOutput(tag, bRecvd, exp);
        end
    endtask

    task automatic pulseClearB();
        bClear = 1'b1;
        stepCycles(1);
        bClear = 1'b0;
    endtask

    initial begin
        int framesBefore;
        int n;
        logic [9:0] frameBits;
        logic [3:0] bitIdx;

        rst = 1'b1; aStart = 1'b0; bStart = 1'b0; aClear = 1'b0; bClear = 1'b0;
        aData = 8'h00; bData = 8'h00; driveRx = 1'b1; useLoop = 1'b0;
        stepCycles(3);
        rst = 1'b0;
        checkOutput("reset_tx", 8'(aTx), 8'd1);
        checkOutput("reset_busyA", 8'(aBusy), 8'd0);
        checkOutput("reset_busyB", 8'(bBusy), 8'd0);
        checkOutput("reset_error", 8'(bError), 8'd0);
        checkOutput("reset_newValue", 8'(bNewValue), 8'd0);
        checkOutput("reset_recvd", bRecvd, 8'h00);

        // Loopback of 0xAA with start held for 10 cycles; data changed after latching.
        useLoop = 1'b1;
        stepCycles(4);
        framesBefore = aFrames;
        expQ.push_back(8'hAA);
        aStart = 1'b1; aData = 8'hAA;
        stepCycles(10);
        aStart = 1'b0; aData = 8'h00;
        waitNewValue("loop_newValue", 12 * BIT);
        popCompare("loop_data");
        checkOutput("loop_error", 8'(bError), 8'd0);
        n = 0;
        while (aBusy !== 1'b0 && n < 12 * BIT) begin stepCycles(1); n++; end
        checkOutput("loop_txDone", 8'(aBusy), 8'd0);
        stepCycles(2 * BIT);
        checkOutput("loop_oneFrame", 8'(aFrames - framesBefore), 8'd1);
        pulseClearB();
        checkOutput("loop_cleared", 8'(bNewValue), 8'd0);

        // Exact tx waveform for 0x35 with a one-cycle request.
        frameBits = {1'b1, 8'h35, 1'b0};
        expQ.push_back(8'h35);
        aStart = 1'b1; aData = 8'h35;
        checkOutput("wave_preIdle", 8'(aTx), 8'd1);
        stepCycles(1);
        aStart = 1'b0;
        for (int cyc = 0; cyc <= 10 * BIT; cyc++) begin
            if (cyc < 10 * BIT && (cyc % BIT == 0 || cyc % BIT == BIT - 1)) begin
                bitIdx = 4'(cyc / BIT);
                checkOutput($sformatf("wave_bit%0d_c%0d", bitIdx, cyc), 8'(aTx), 8'(frameBits[bitIdx]));
            end
            if (cyc == 10 * BIT - 1) checkOutput("wave_busyLast", 8'(aBusy), 8'd1);
            if (cyc == 10 * BIT) begin
                checkOutput("wave_busyFall", 8'(aBusy), 8'd0);
                checkOutput("wave_idleHigh", 8'(aTx), 8'd1);
            end
            if (cyc < 10 * BIT) stepCycles(1);
        end
        waitNewValue("wave_newValue", 2 * BIT);
        popCompare("wave_rxData");
        pulseClearB();

        // Framing error: stop bit driven low.
        useLoop = 1'b0;
        stepCycles(5);
        applyStimulus(8'h5C, 1'b0);
        stepCycles(5);
        checkOutput("frame_error", 8'(bError), 8'd1);
        checkOutput("frame_newValue", 8'(bNewValue), 8'd0);
        checkOutput("frame_recvdKept", bRecvd, 8'h35);
        pulseClearB();
        checkOutput("frame_errorCleared", 8'(bError), 8'd0);

        // Overrun: two bytes without a clear in between.
        stepCycles(BIT);
        expQ.push_back(8'h12);
        applyStimulus(8'h12, 1'b1);
        stepCycles(5);
        waitNewValue("ovr_first", 2 * BIT);
        popCompare("ovr_data1");
        checkOutput("ovr_noErrorYet", 8'(bError), 8'd0);
        expQ.push_back(8'h34);
        applyStimulus(8'h34, 1'b1);
        stepCycles(5);
        popCompare("ovr_data2");
        checkOutput("ovr_error", 8'(bError), 8'd1);
        checkOutput("ovr_newValue", 8'(bNewValue), 8'd1);
        pulseClearB();
        checkOutput("ovr_clearedErr", 8'(bError), 8'd0);
        checkOutput("ovr_clearedNv", 8'(bNewValue), 8'd0);

        // Clear lands on the cycle the byte completes: the set must win.
        stepCycles(BIT);
        expQ.push_back(8'h77);
        fork
            applyStimulus(8'h77, 1'b1);
            begin
                stepCycles(2 + HALF + 9 * BIT);
                bClear = 1'b1;
                stepCycles(1);
                bClear = 1'b0;
            end
        join
        stepCycles(5);
        checkOutput("clrRace_newValue", 8'(bNewValue), 8'd1);
        checkOutput("clrRace_error", 8'(bError), 8'd0);
        popCompare("clrRace_data");

        // Reset in the middle of a transmitted frame.
        useLoop = 1'b1;
        stepCycles(5);
        aStart = 1'b1; aData = 8'hC3;
        stepCycles(1);
        aStart = 1'b0;
        stepCycles(3 * BIT + 17);
        checkOutput("rstMid_busyBefore", 8'(aBusy), 8'd1);
        rst = 1'b1;
        stepCycles(1);
        rst = 1'b0;
        checkOutput("rstMid_tx", 8'(aTx), 8'd1);
        checkOutput("rstMid_busyA", 8'(aBusy), 8'd0);
        checkOutput("rstMid_busyB", 8'(bBusy), 8'd0);
        checkOutput("rstMid_newValue", 8'(bNewValue), 8'd0);
        checkOutput("rstMid_error", 8'(bError), 8'd0);
        checkOutput("rstMid_recvd", bRecvd, 8'h00);
        stepCycles(BIT);
        checkOutput("rstMid_staysIdle", 8'(aTx), 8'd1);

        // Short low glitch on rx is rejected as a false start.
        useLoop = 1'b0;
        driveRx = 1'b1;
        stepCycles(5);
        driveRx = 1'b0;
        stepCycles(10);
        checkOutput("glitch_rxBusy", 8'(bBusy), 8'd1);
        stepCycles(20);
        driveRx = 1'b1;
        stepCycles(2 * BIT);
        checkOutput("glitch_idle", 8'(bBusy), 8'd0);
        checkOutput("glitch_newValue", 8'(bNewValue), 8'd0);
        checkOutput("glitch_error", 8'(bError), 8'd0);
        checkOutput("glitch_queueEmpty", 8'(expQ.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
